run_sequencer: RTL and testbench

- Host-side controller directly upstream of the core top level. It drives the core's req input and consumes its ack output.
- Runs a configurable number of back-to-back program executions through the req/ack handshake and measures the cycle count of each run.
- Enforces a watchdog timeout and stores per-run results in a small readable result buffer.
- Gives the testbench and any FPGA wrapper one go/done interface in place of raw req/ack.

---
 rtl/run_sequencer_pkg.sv | 23 ++
 rtl/run_result_buffer.sv | 36 +++
 rtl/run_sequencer.sv | 155 +++++++++++++++
 tb/tb_run_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer: default sizing, FSM states and
// the per-run result record stored in the result buffer.
package run_sequencer_pkg;

  localparam int unsigned RS_RUNS       = 3;
  localparam int unsigned RS_CNT_BITS   = 16;
  localparam int unsigned RS_REQ_CYCLES = 2;
  localparam int unsigned RS_MAX_CYCLES = 4096;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RUN,
    GAP,
    FIN
  } run_state_t;

  typedef struct packed {
    logic [RS_CNT_BITS-1:0] count;
    logic                   timedout;
  } run_result_t;

endpackage

// File: rtl/run_result_buffer.sv
// Small register array holding one record per run: synchronous write,
// asynchronous read, out-of-range read indices return zero.
module run_result_buffer #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned W     = 17,
  parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [W-1:0]     i_wr_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [W-1:0]     o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en && (32'(i_wr_idx) < DEPTH)) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (32'(i_rd_idx) < DEPTH) begin
      o_rd_data = r_mem[i_rd_idx];
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Host-side go/done controller for the core: issues RUNS req pulses, times
// each run against a watchdog and records the per-run cycle counts.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int unsigned RUNS       = RS_RUNS,
  parameter int unsigned CNT_BITS   = RS_CNT_BITS,
  parameter int unsigned REQ_CYCLES = RS_REQ_CYCLES,
  parameter int unsigned MAX_CYCLES = RS_MAX_CYCLES
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      go,
  output logic                      req,
  input  logic                      ack,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic [$clog2(RUNS):0]     run_idx,
  input  logic [$clog2(RUNS)-1:0]   rd_idx,
  output logic [CNT_BITS-1:0]       rd_count,
  output logic                      rd_timedout
);

  localparam int unsigned RUN_W = $clog2(RUNS) + 1;
  localparam int unsigned IDX_W = $clog2(RUNS);
  localparam int unsigned REQ_W = $clog2(REQ_CYCLES) + 1;
  localparam int unsigned RES_W = $bits(run_result_t);

  if (64'(MAX_CYCLES) >= (64'd1 << CNT_BITS)) begin : g_bad_max
    $error("run_sequencer: MAX_CYCLES must be below 2**CNT_BITS");
  end
  if (CNT_BITS != RS_CNT_BITS) begin : g_bad_width
    $error("run_sequencer: CNT_BITS must match the result record width");
  end
  if ((RUNS < 2) || (REQ_CYCLES < 1)) begin : g_bad_size
    $error("run_sequencer: RUNS must be >= 2 and REQ_CYCLES >= 1");
  end

  run_state_t          r_state;
  logic [REQ_W-1:0]    r_req_cnt;
  logic [CNT_BITS-1:0] r_cyc_cnt;
  logic [RUN_W-1:0]    r_run_idx;
  logic                r_req;
  logic                r_busy;
  logic                r_done;
  logic                r_timeout;

  logic                w_limit;
  logic                w_run_end;
  run_result_t         w_wr_data;
  run_result_t         w_rd_data;
  logic [RES_W-1:0]    w_rd_raw;

  // A run ends on ack or on the watchdog limit; ack wins when both coincide.
  assign w_limit   = (r_cyc_cnt == CNT_BITS'(MAX_CYCLES));
  assign w_run_end = (r_state == RUN) && (ack || w_limit);

  always_comb begin
    w_wr_data          = '0;
    w_wr_data.count    = r_cyc_cnt;
    w_wr_data.timedout = ~ack;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_req_cnt <= '0;
      r_cyc_cnt <= '0;
      r_run_idx <= '0;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (go) begin
            r_state   <= REQ;
            r_run_idx <= '0;
            r_timeout <= 1'b0;
            r_req_cnt <= '0;
            r_req     <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        REQ: begin
          r_req_cnt <= r_req_cnt + REQ_W'(1);
          if (r_req_cnt == REQ_W'(REQ_CYCLES - 1)) begin
            r_state   <= RUN;
            r_req     <= 1'b0;
            r_cyc_cnt <= '0;
          end
        end
        RUN: begin
          if (w_run_end) begin
            r_state <= GAP;
            if (!ack) begin
              r_timeout <= 1'b1;
            end
          end else if (r_cyc_cnt != '1) begin
            r_cyc_cnt <= r_cyc_cnt + CNT_BITS'(1);
          end
        end
        GAP: begin
          r_run_idx <= r_run_idx + RUN_W'(1);
          if (r_run_idx == RUN_W'(RUNS - 1)) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= REQ;
            r_req_cnt <= '0;
            r_req     <= 1'b1;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  run_result_buffer #(
    .DEPTH (RUNS),
    .W     (RES_W),
    .IDX_W (IDX_W)
  ) u_result_buffer (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_wr_en   (w_run_end),
    .i_wr_idx  (r_run_idx[IDX_W-1:0]),
    .i_wr_data (w_wr_data),
    .i_rd_idx  (rd_idx),
    .o_rd_data (w_rd_raw)
  );

  assign w_rd_data   = run_result_t'(w_rd_raw);
  assign rd_count    = w_rd_data.count;
  assign rd_timedout = w_rd_data.timedout;

  assign req     = r_req;
  assign busy    = r_busy;
  assign done    = r_done;
  assign timeout = r_timeout;
  assign run_idx = r_run_idx;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: a core model answers each req with a
// programmed ack delay; expected counts, flags and done timing come from arithmetic.
module tb_run_sequencer;

  localparam int NRUN = 3;
  localparam int REQC = 2;
  localparam int MAXC = 20;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        go;
  logic        req;
  logic        ack;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [2:0]  run_idx;
  logic [1:0]  rd_idx;
  logic [15:0] rd_count;
  logic        rd_timedout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int d0; int d1; int d2;
    bit early; bit noise;
    int c0; int c1; int c2;
    bit t0; bit t1; bit t2;
    bit to_any;
  } vec_t;

  run_sequencer #(
    .RUNS       (NRUN),
    .CNT_BITS   (16),
    .REQ_CYCLES (REQC),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .go          (go),
    .req         (req),
    .ack         (ack),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .run_idx     (run_idx),
    .rd_idx      (rd_idx),
    .rd_count    (rd_count),
    .rd_timedout (rd_timedout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: a run acked d cycles after req falls records min(d, MAXC),
  // and is a timeout only when the ack would come after the limit.
  function automatic vec_t model(input int d0, input int d1, input int d2,
                                 input bit early, input bit noise);
    vec_t v;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.early = early; v.noise = noise;
    v.c0 = (d0 > MAXC) ? MAXC : d0;
    v.c1 = (d1 > MAXC) ? MAXC : d1;
    v.c2 = (d2 > MAXC) ? MAXC : d2;
    v.t0 = (d0 > MAXC); v.t1 = (d1 > MAXC); v.t2 = (d2 > MAXC);
    v.to_any = v.t0 | v.t1 | v.t2;
    return v;
  endfunction

  task automatic run_job(input vec_t v, input int abort_t, input string nm);
    int dl[3];
    int ec[3];
    bit et[3];
    int exp_t, rs, j, req_hi, done_cnt, done_t, busy_low;
    bit prev_req;
    logic busy_fin, to_fin;
    dl = '{v.d0, v.d1, v.d2};
    ec = '{v.c0, v.c1, v.c2};
    et = '{v.t0, v.t1, v.t2};
    exp_t = 0;
    for (int r = 0; r < NRUN; r++) exp_t += ec[r] + REQC + 2;
    rs = 0; j = 0; prev_req = 1'b0; req_hi = 0; done_cnt = 0; done_t = -1; busy_low = 0;
    busy_fin = 1'b1; to_fin = ~v.to_any;
    ack = 1'b0;
    go  = 1'b1;
    @(negedge clock);
    go = 1'b0;
    for (int t = 0; t < exp_t + 12; t++) begin
      if (t == abort_t) begin
        rd_idx = 2'd0;
        #1;
        chk({nm, "_pre_rst_r0"}, rd_count, ec[0]);
        reset_n = 1'b0;
        #1;
        chk({nm, "_rst_req"}, req, 0);
        chk({nm, "_rst_busy"}, busy, 0);
        chk({nm, "_rst_run_idx"}, run_idx, 0);
        chk({nm, "_rst_buf_count"}, rd_count, 0);
        chk({nm, "_rst_buf_to"}, rd_timedout, 0);
        @(negedge clock);
        reset_n = 1'b1;
        ack = 1'b0;
        @(negedge clock);
        return;
      end
      if (req) req_hi++;
      if (done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      if (t < exp_t && !busy) busy_low++;
      if (t == exp_t) begin
        busy_fin = busy;
        to_fin   = timeout;
      end
      if (t == 0) chk({nm, "_timeout_cleared"}, timeout, 0);
      // Core model: PC held in reset while req is high, done address reached d cycles later.
      if (prev_req && !req) begin
        rs++;
        j = 0;
      end else if (!req) begin
        j++;
      end
      if (req) ack = v.early;
      else if (rs > 0 && rs <= NRUN) ack = (j >= dl[rs-1]);
      else ack = 1'b0;
      go = v.noise && (t == 3 || t == exp_t);
      prev_req = req;
      @(negedge clock);
    end
    go = 1'b0;
    chk({nm, "_done_time"}, done_t, exp_t);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_req_cycles"}, req_hi, NRUN * REQC);
    chk({nm, "_busy_drops"}, busy_low, 0);
    chk({nm, "_busy_in_fin"}, busy_fin, 0);
    chk({nm, "_timeout_at_done"}, to_fin, v.to_any);
    chk({nm, "_run_idx_end"}, run_idx, NRUN);
    for (int r = 0; r < NRUN; r++) begin
      rd_idx = 2'(r);
      #1;
      chk($sformatf("%s_count%0d", nm, r), rd_count, ec[r]);
      chk($sformatf("%s_tout%0d", nm, r), rd_timedout, et[r]);
    end
    rd_idx = 2'd3;
    #1;
    chk({nm, "_oob_count"}, rd_count, 0);
    chk({nm, "_oob_tout"}, rd_timedout, 0);
    @(negedge clock);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{10, 10, 10, 1'b0, 1'b0, 10, 10, 10, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{5, 999, 7, 1'b0, 1'b0, 5, 20, 7, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1, 2, 3, 1'b0, 1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{20, 20, 3, 1'b0, 1'b0, 20, 20, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{21, 0, 1, 1'b1, 1'b0, 20, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{4, 6, 8, 1'b0, 1'b1, 4, 6, 8, 1'b0, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0;
    go      = 1'b0;
    ack     = 1'b0;
    rd_idx  = 2'd0;
    repeat (3) @(negedge clock);
    chk("reset_req", req, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_run_idx", run_idx, 0);
    chk("reset_buf", rd_count, 0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      run_job(tbl[i], -1, $sformatf("vec%0d", i));
    end

    // Reset during RUN of run 1 (run 0 spans 14 cycles, run 1 RUN starts at 16).
    run_job(model(10, 10, 10, 1'b0, 1'b0), 19, "abort");
    run_job(tbl[0], -1, "post_abort");

    for (int i = 0; i < 6; i++) begin
      int a, b, c;
      bit e;
      a = int'($urandom_range(0, 24));
      b = int'($urandom_range(0, 24));
      c = int'($urandom_range(0, 24));
      e = 1'($urandom_range(0, 1));
      run_job(model(a, b, c, e, 1'($urandom_range(0, 1))), -1, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
